// File: rtl/conv_seq_pkg.sv
// Shared types and constants for the matched-filter convolution sequencer.
package conv_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;

  // Address-to-product latency of the coefficient multiplier stage.
  localparam int PIPE_LAT   = 2;

  localparam int MULT_N_DEF = 50;
  localparam int NOUT_DEF   = 256;

endpackage

// File: rtl/conv_tap_accumulator.sv
// Signed load/add accumulator: the first tap of an output loads the
// sign-extended product, later taps add to the running sum.
module conv_tap_accumulator #(
  parameter int ACC_W = 38
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic                    first_i,
  input  logic signed [31:0]      prod_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] prod_ext;

  assign prod_ext = {{(ACC_W-32){prod_i[31]}}, prod_i};
  assign acc_o    = acc_q;

  // Load on the first tap, accumulate on the rest; hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= first_i ? prod_ext : acc_q + prod_ext;
    end
  end

endmodule

// File: rtl/convolution_sequencer.sv
// Frame controller for the matched-filter multiply stage: sweeps coefficient
// and sample addresses per output, accumulates I/Q products over MULT_N taps
// and hands each result pair downstream with valid/ready.
module convolution_sequencer
  import conv_seq_pkg::*;
#(
  parameter int MULT_N = MULT_N_DEF,
  parameter int NOUT   = NOUT_DEF,
  parameter int NLOG   = $clog2(MULT_N),
  parameter int DLOG   = $clog2(NOUT + MULT_N - 1),
  parameter int ACC_W  = 32 + NLOG
) (
  input  logic                    clkf,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    coef_busy,
  input  logic signed [31:0]      PROD_A,
  input  logic signed [31:0]      PROD_B,
  input  logic                    out_ready,
  output logic [NLOG-1:0]         ADDRB_RAMK,
  output logic [DLOG-1:0]         DATA_ADDR,
  output logic                    busy,
  output logic                    done,
  output logic                    acc_valid,
  output logic signed [ACC_W-1:0] ACC_OUT_A,
  output logic signed [ACC_W-1:0] ACC_OUT_B
);

  localparam int             DRW    = $clog2(PIPE_LAT + 1);
  localparam logic [NLOG-1:0] K_LAST = NLOG'(MULT_N - 1);
  localparam logic [DLOG-1:0] N_LAST = DLOG'(NOUT - 1);
  localparam logic [DRW-1:0]  D_LAST = DRW'(PIPE_LAT - 1);

  state_e          state_q;
  logic [NLOG-1:0] k_q;
  logic [DLOG-1:0] n_q;
  logic [DLOG-1:0] daddr_q;
  logic [DRW-1:0]  drain_q;
  logic            busy_q;
  logic            done_q;
  logic            valid_q;

  // Tap-tracking flags, one bit per cycle of product latency.
  logic [PIPE_LAT:1] vld_pipe_q;
  logic [PIPE_LAT:1] first_pipe_q;

  logic issue;
  logic acc_en;

  assign issue  = (state_q == RUN);
  // A tap retiring in the abort cycle is dropped with the rest of the frame.
  assign acc_en = vld_pipe_q[PIPE_LAT] && !abort;

  assign ADDRB_RAMK = k_q;
  assign DATA_ADDR  = daddr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign acc_valid  = valid_q;

  // Frame FSM: tap/output counters, addresses and registered status outputs.
  always_ff @(posedge clkf or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      n_q     <= '0;
      daddr_q <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start && !coef_busy) begin
              state_q <= RUN;
              n_q     <= '0;
              k_q     <= '0;
              daddr_q <= '0;
              busy_q  <= 1'b1;
            end
          end
          RUN: begin
            if (k_q == K_LAST) begin
              state_q <= DRAIN;
              drain_q <= '0;
            end else begin
              k_q     <= k_q + NLOG'(1);
              daddr_q <= daddr_q + DLOG'(1);
            end
          end
          DRAIN: begin
            // Wait out the product latency so the last tap has landed.
            if (drain_q == D_LAST) begin
              state_q <= OUT;
              valid_q <= 1'b1;
            end else begin
              drain_q <= drain_q + DRW'(1);
            end
          end
          OUT: begin
            if (out_ready) begin
              valid_q <= 1'b0;
              if (n_q == N_LAST) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= RUN;
                n_q     <= n_q + DLOG'(1);
                k_q     <= '0;
                daddr_q <= n_q + DLOG'(1);
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Valid / first-tap flags ride alongside the addresses to meet the products.
  always_ff @(posedge clkf or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q   <= '0;
      first_pipe_q <= '0;
    end else if (abort) begin
      vld_pipe_q   <= '0;
      first_pipe_q <= '0;
    end else begin
      vld_pipe_q[1]   <= issue;
      first_pipe_q[1] <= issue && (k_q == '0);
      for (int i = 2; i <= PIPE_LAT; i++) begin
        vld_pipe_q[i]   <= vld_pipe_q[i-1];
        first_pipe_q[i] <= first_pipe_q[i-1];
      end
    end
  end

  conv_tap_accumulator #(.ACC_W(ACC_W)) u_acc_a (
    .clk     (clkf),
    .rst_n   (rst_n),
    .en_i    (acc_en),
    .first_i (first_pipe_q[PIPE_LAT]),
    .prod_i  (PROD_A),
    .acc_o   (ACC_OUT_A)
  );

  conv_tap_accumulator #(.ACC_W(ACC_W)) u_acc_b (
    .clk     (clkf),
    .rst_n   (rst_n),
    .en_i    (acc_en),
    .first_i (first_pipe_q[PIPE_LAT]),
    .prod_i  (PROD_B),
    .acc_o   (ACC_OUT_B)
  );

endmodule

// File: tb/tb_convolution_sequencer.sv
// Directed bench for convolution_sequencer: models the 2-cycle multiplier
// latency and walks every tap of each frame against an independent model.
module tb_convolution_sequencer;

  localparam int MULT_N = 50;
  localparam int NOUT   = 256;
  localparam int NLOG   = 6;
  localparam int DLOG   = 9;
  localparam int ACC_W  = 38;

  logic                    clkf      = 1'b0;
  logic                    rst_n     = 1'b0;
  logic                    start     = 1'b0;
  logic                    abort     = 1'b0;
  logic                    coef_busy = 1'b0;
  logic                    out_ready = 1'b1;
  logic signed [31:0]      PROD_A    = '0;
  logic signed [31:0]      PROD_B    = '0;
  logic [NLOG-1:0]         ADDRB_RAMK;
  logic [DLOG-1:0]         DATA_ADDR;
  logic                    busy;
  logic                    done;
  logic                    acc_valid;
  logic signed [ACC_W-1:0] ACC_OUT_A;
  logic signed [ACC_W-1:0] ACC_OUT_B;

  int n_cmp = 0;
  int n_err = 0;
  int mode  = 0;   // 0: +1/-1, 1: extremes, 2: address-dependent
  logic signed [31:0] pa1 = '0;
  logic signed [31:0] pb1 = '0;

  always #5 clkf = ~clkf;

  convolution_sequencer #(.MULT_N(MULT_N), .NOUT(NOUT)) dut (
    .clkf       (clkf),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .coef_busy  (coef_busy),
    .PROD_A     (PROD_A),
    .PROD_B     (PROD_B),
    .out_ready  (out_ready),
    .ADDRB_RAMK (ADDRB_RAMK),
    .DATA_ADDR  (DATA_ADDR),
    .busy       (busy),
    .done       (done),
    .acc_valid  (acc_valid),
    .ACC_OUT_A  (ACC_OUT_A),
    .ACC_OUT_B  (ACC_OUT_B)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // One clock: products for the current addresses appear two cycles later.
  task automatic tick();
    logic signed [31:0] fa, fb;
    if (mode == 0) begin
      fa = 32'sd1;
      fb = -32'sd1;
    end else if (mode == 1) begin
      fa = 32'sh8000_0000;
      fb = 32'sh7fff_ffff;
    end else begin
      fa = $signed({23'b0, DATA_ADDR});
      fb = $signed({26'b0, ADDRB_RAMK}) - 32'sd100;
    end
    @(posedge clkf);
    #1;
    PROD_A = pa1;
    PROD_B = pb1;
    pa1    = fa;
    pb1    = fb;
  endtask

  function automatic longint exp_a(input int n);
    if (mode == 0)      return 64'sd50;
    else if (mode == 1) return -64'sd107374182400;
    else                return longint'(50 * n + 1225);
  endfunction

  function automatic longint exp_b();
    if (mode == 0)      return -64'sd50;
    else if (mode == 1) return 64'sd107374182350;
    else                return -64'sd3775;
  endfunction

  // Run a frame from start; optional stall (10 cycles) at output stall_at,
  // optional abort at tap 20 of output abort_n.
  task automatic run_frame(input int stall_at, input int abort_n);
    int n, p, stall, nres, cyc;
    bit fin, aborted;
    n = 0; p = 0; stall = 0; nres = 0; cyc = 0; fin = 0; aborted = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!fin && !aborted && cyc < 20000) begin
      if (p < MULT_N) begin
        chk("addr_k", ADDRB_RAMK, p);
        chk("addr_d", DATA_ADDR, n + p);
        if (p == 0) begin
          chk("run_valid", acc_valid, 0);
          chk("run_busy", busy, 1);
          chk("run_done", done, 0);
        end
      end else begin
        chk("hold_k", ADDRB_RAMK, MULT_N - 1);
        chk("hold_d", DATA_ADDR, n + MULT_N - 1);
        chk("valid", acc_valid, (p >= MULT_N + 2));
        if (p >= MULT_N + 2) begin
          chk("acc_a", ACC_OUT_A, exp_a(n));
          chk("acc_b", ACC_OUT_B, exp_b());
        end
      end
      start     = (n == 1) && (p == 10 || p == MULT_N + 2);
      coef_busy = (n == 2);
      out_ready = !(n == stall_at && p >= MULT_N + 2 && stall < 10);
      if (!out_ready) stall++;
      if (n == abort_n && p == 20) abort = 1'b1;
      tick();
      cyc++;
      if (abort) begin
        abort   = 1'b0;
        aborted = 1;
      end else if (p >= MULT_N + 2) begin
        if (out_ready) begin
          nres++;
          if (n == NOUT - 1) fin = 1;
          else begin
            n++;
            p = 0;
          end
        end
      end else begin
        p++;
      end
    end
    start = 1'b0; coef_busy = 1'b0; out_ready = 1'b1;
    if (aborted) begin
      chk("abort_busy", busy, 0);
      chk("abort_valid", acc_valid, 0);
      chk("abort_done", done, 0);
      repeat (5) begin
        tick();
        chk("abort_valid_after", acc_valid, 0);
        chk("abort_done_after", done, 0);
      end
    end else begin
      chk("done", done, 1);
      chk("frame_cycles", cyc, NOUT * (MULT_N + 3) + ((stall_at >= 0) ? 10 : 0));
      chk("results", nres, NOUT);
      chk("end_busy", busy, 0);
      chk("end_valid", acc_valid, 0);
      tick();
      chk("done_pulse", done, 0);
    end
  endtask

  initial begin
    // reset values
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_addr_k", ADDRB_RAMK, 0);
    chk("rst_addr_d", DATA_ADDR, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", acc_valid, 0);
    chk("rst_acc_a", ACC_OUT_A, 0);
    chk("rst_acc_b", ACC_OUT_B, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // start with coefficient reload in progress is ignored
    coef_busy = 1'b1;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    coef_busy = 1'b0;
    chk("gate_busy", busy, 0);
    chk("gate_addr_k", ADDRB_RAMK, 0);
    tick();
    chk("gate_busy2", busy, 0);

    // nominal frame
    mode = 0;
    run_frame(-1, -1);

    // extreme products with backpressure at output 3
    mode = 1;
    run_frame(3, -1);

    // address-dependent products, abort at output 5 tap 20, then restart
    mode = 2;
    run_frame(-1, 5);
    run_frame(-1, 1);

    // asynchronous reset mid-RUN
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("mid_busy", busy, 1);
    chk("mid_addr_k", ADDRB_RAMK, 10);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_addr_k", ADDRB_RAMK, 0);
    chk("arst_addr_d", DATA_ADDR, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_valid", acc_valid, 0);
    chk("arst_acc_a", ACC_OUT_A, 0);
    chk("arst_acc_b", ACC_OUT_B, 0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("post_busy", busy, 0);
    chk("post_addr_k", ADDRB_RAMK, 0);
    chk("post_addr_d", DATA_ADDR, 0);
    chk("post_valid", acc_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
